alu_wreg_core: RTL and testbench

ALU_WREG_CORE -- requirements
Module: alu_wreg_core

---
 rtl/alu_wreg_pkg.sv | 23 ++
 rtl/alu_wreg_datapath.sv | 45 ++++
 rtl/alu_wreg_core.sv | 50 +++++
 tb/tb_alu_wreg_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wreg_pkg.sv
// Shared constants and the opcode encoding for the ALU / working-register core.
// The shift opcodes are only decoded when ALU_SHIFT_EN is defined (see alu_wreg_datapath).
package alu_wreg_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PC_W_DEF   = 17;

    // Opcodes 11..15 are unassigned and act as pass-w.
    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10
    } alu_op_e;

endpackage

// File: rtl/alu_wreg_datapath.sv
// Purely combinational ALU: operand A is the working register, operand B the input bus.
// Build option ALU_SHIFT_EN enables SHL/SHR; without it those opcodes pass w through.
module alu_wreg_datapath
    import alu_wreg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        inst,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   ans
);

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    alu_op_e         op;
    logic [DATA_W:0] w_ext;
    logic [DATA_W:0] b_ext;

    assign op    = alu_op_e'(inst);
    assign w_ext = {1'b0, w};
    assign b_ext = {1'b0, b};

    // Bit DATA_W carries out of ADD/INC and is the borrow of SUB/DEC.
    always_comb begin
        ans = w_ext;
        case (op)
            OP_LOAD: ans = b_ext;
            OP_ADD:  ans = w_ext + b_ext;
            OP_SUB:  ans = w_ext - b_ext;
            OP_AND:  ans = {1'b0, w & b};
            OP_OR:   ans = {1'b0, w | b};
            OP_XOR:  ans = {1'b0, w ^ b};
            OP_NOT:  ans = {1'b0, ~w};
`ifdef ALU_SHIFT_EN
            OP_SHL:  ans = {w, 1'b0};
            OP_SHR:  ans = {w[0], 1'b0, w[DATA_W-1:1]};
`endif
            OP_INC:  ans = w_ext + ONE;
            OP_DEC:  ans = w_ext - ONE;
            default: ans = w_ext;
        endcase
    end

endmodule

// File: rtl/alu_wreg_core.sv
// Working-register ALU core: free-running counter, W register and carry flag around
// alu_wreg_datapath. Shift opcodes depend on the ALU_SHIFT_EN build macro.
module alu_wreg_core
    import alu_wreg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        inst,
    input  logic [DATA_W-1:0] b,
    input  logic              d,
    output logic [PC_W-1:0]   counter,
    output logic [DATA_W-1:0] w,
    output logic [DATA_W:0]   ans,
    output logic              carry
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [DATA_W:0] alu_ans;

    alu_wreg_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .inst (inst),
        .w    (w),
        .b    (b),
        .ans  (alu_ans)
    );

    // The visible result is forced to zero for the whole time reset is held.
    assign ans = reset ? '0 : alu_ans;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            w       <= '0;
            carry   <= 1'b0;
        end else begin
            counter <= counter + PC_ONE;
            if (!d) begin
                w     <= alu_ans[DATA_W-1:0];
                carry <= alu_ans[DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_wreg_core.sv
// Self-checking bench for alu_wreg_core: a reference model checked every cycle plus
// hand-computed directed expectations. Counter is narrowed to 12 bits so wrap is quick.
module tb_alu_wreg_core;

    localparam int DATA_W = 8;
    localparam int PC_W   = 12;
    localparam int PC_MOD = 1 << PC_W;

    logic              clk;
    logic              reset;
    logic [3:0]        inst;
    logic [DATA_W-1:0] b;
    logic              d;
    logic [PC_W-1:0]   counter;
    logic [DATA_W-1:0] w;
    logic [DATA_W:0]   ans;
    logic              carry;

    int checks = 0;
    int errors = 0;

    alu_wreg_core #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst),
        .b       (b),
        .d       (d),
        .counter (counter),
        .w       (w),
        .ans     (ans),
        .carry   (carry)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference ALU from the opcode table, in plain integer arithmetic.
    function automatic logic [8:0] ref_ans(input logic [3:0] op, input logic [7:0] wv,
                                           input logic [7:0] bv);
        int a;
        int c;
        int r;
        a = int'(wv);
        c = int'(bv);
        case (op)
            4'd0:  r = c;
            4'd1:  r = a + c;
            4'd2:  r = a - c;
            4'd3:  r = a & c;
            4'd4:  r = a | c;
            4'd5:  r = a ^ c;
            4'd6:  r = 255 - a;
`ifdef ALU_SHIFT_EN
            4'd7:  r = a * 2;
            4'd8:  r = a / 2 + (a % 2) * 256;
`endif
            4'd9:  r = a + 1;
            4'd10: r = a - 1;
            default: r = a;
        endcase
        if (r < 0) r = r + 512;
        return r[8:0];
    endfunction

    // Model state, advanced on each rising edge from the stable inputs.
    int               m_cnt = 0;
    logic [7:0]       m_w = 8'h00;
    logic             m_c = 1'b0;
    bit               started = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    always @(posedge clk) begin
        logic [8:0] r;
        if (reset) begin
            m_cnt = 0;
            m_w = 8'h00;
            m_c = 1'b0;
            started = 1'b1;
        end else if (started) begin
            m_cnt = (m_cnt + 1) % PC_MOD;
            if (!d) begin
                r = ref_ans(inst, m_w, b);
                m_w = r[7:0];
                m_c = r[8];
            end
        end
        if (started) exp_q.push_back(m_w);
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        logic [8:0] exp_ans;
        if (started && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            exp_ans = reset ? 9'h000 : ref_ans(inst, m_w, b);
            check("sb_w", 32'(w), 32'(exp_w));
            check("sb_carry", 32'(carry), 32'(m_c));
            check("sb_counter", 32'(counter), 32'(m_cnt));
            check("sb_ans", 32'(ans), 32'(exp_ans));
        end
    end

    // Driver tasks
    task automatic drive(input logic [3:0] i, input logic [7:0] bv, input logic dv,
                         input logic rv);
        inst = i;
        b = bv;
        d = dv;
        reset = rv;
        #1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        inst = 4'd0;
        b = 8'h00;
        d = 1'b0;

        // Reset pulse; ans must read zero even with an ADD on the bus.
        tick(1);
        drive(4'd1, 8'h05, 1'b0, 1'b1);
        check("reset_ans", 32'(ans), 32'h0);
        check("reset_counter", 32'(counter), 32'h0);
        check("reset_w", 32'(w), 32'h0);
        check("reset_carry", 32'(carry), 32'h0);
        drive(4'd1, 8'h05, 1'b1, 1'b0);
        tick(5);
        check("counter_after_5", 32'(counter), 32'd5);

        // Load then add
        drive(4'd0, 8'd10, 1'b0, 1'b0);
        check("load_ans", 32'(ans), 32'd10);
        tick(1);
        check("load_w", 32'(w), 32'd10);
        drive(4'd1, 8'd10, 1'b0, 1'b0);
        check("add_ans", 32'(ans), 32'd20);
        tick(1);
        check("add_w", 32'(w), 32'd20);

        // Borrow
        drive(4'd0, 8'd3, 1'b0, 1'b0);
        tick(1);
        drive(4'd2, 8'd4, 1'b0, 1'b0);
        check("sub_ans", 32'(ans), 32'h1FF);
        tick(1);
        check("sub_w", 32'(w), 32'hFF);
        check("sub_carry", 32'(carry), 32'h1);

        // Hold with d = 1
        drive(4'd0, 8'd3, 1'b0, 1'b0);
        tick(1);
        drive(4'd1, 8'd1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("hold_ans", 32'(ans), 32'd4);
            tick(1);
            check("hold_w", 32'(w), 32'd3);
        end

        // Opcode table with w = 0x81, result discarded
        drive(4'd0, 8'h81, 1'b0, 1'b0);
        tick(1);
        drive(4'd7, 8'h00, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
        check("shl_ans", 32'(ans), 32'h102);
        drive(4'd8, 8'h00, 1'b1, 1'b0);
        check("shr_ans", 32'(ans), 32'h140);
`else
        check("shl_ans", 32'(ans), 32'h081);
        drive(4'd8, 8'h00, 1'b1, 1'b0);
        check("shr_ans", 32'(ans), 32'h081);
`endif
        drive(4'd3, 8'h0F, 1'b1, 1'b0);  check("and_ans", 32'(ans), 32'h001);
        drive(4'd4, 8'h0F, 1'b1, 1'b0);  check("or_ans", 32'(ans), 32'h08F);
        drive(4'd5, 8'hFF, 1'b1, 1'b0);  check("xor_ans", 32'(ans), 32'h07E);
        drive(4'd6, 8'h00, 1'b1, 1'b0);  check("not_ans", 32'(ans), 32'h07E);
        drive(4'd9, 8'h00, 1'b1, 1'b0);  check("inc_ans", 32'(ans), 32'h082);
        drive(4'd10, 8'h00, 1'b1, 1'b0); check("dec_ans", 32'(ans), 32'h080);
        drive(4'd12, 8'h55, 1'b1, 1'b0); check("pass_ans", 32'(ans), 32'h081);
        drive(4'd15, 8'hAA, 1'b1, 1'b0); check("pass15_ans", 32'(ans), 32'h081);
        drive(4'd1, 8'h80, 1'b1, 1'b0);  check("add_ovf_ans", 32'(ans), 32'h101);
        tick(1);
        check("hold_w_81", 32'(w), 32'h81);

        // Accumulate: ADD 0x80 twice from 0x81
        drive(4'd1, 8'h80, 1'b0, 1'b0);
        tick(1);
        check("acc1_w", 32'(w), 32'h01);
        check("acc1_carry", 32'(carry), 32'h1);
        tick(1);
        check("acc2_w", 32'(w), 32'h81);
        check("acc2_carry", 32'(carry), 32'h0);

        // INC wrap and DEC borrow
        drive(4'd0, 8'hFF, 1'b0, 1'b0);
        tick(1);
        drive(4'd9, 8'h00, 1'b0, 1'b0);
        check("inc_wrap_ans", 32'(ans), 32'h100);
        tick(1);
        check("inc_wrap_w", 32'(w), 32'h00);
        check("inc_wrap_carry", 32'(carry), 32'h1);
        drive(4'd10, 8'h00, 1'b0, 1'b0);
        check("dec_borrow_ans", 32'(ans), 32'h1FF);
        tick(1);
        check("dec_borrow_w", 32'(w), 32'hFF);

        // Counter wrap after reset
        drive(4'd0, 8'h00, 1'b1, 1'b1);
        tick(1);
        drive(4'd0, 8'h00, 1'b1, 1'b0);
        tick(PC_MOD - 1);
        check("counter_max", 32'(counter), 32'(PC_MOD - 1));
        tick(1);
        check("counter_wrap", 32'(counter), 32'h0);

        // Reset in the middle of an ADD run
        drive(4'd1, 8'd7, 1'b0, 1'b0);
        tick(3);
        check("mid_add_w", 32'(w), 32'd21);
        drive(4'd1, 8'd7, 1'b0, 1'b1);
        tick(1);
        check("mid_reset_w", 32'(w), 32'h0);
        check("mid_reset_counter", 32'(counter), 32'h0);
        check("mid_reset_carry", 32'(carry), 32'h0);
        drive(4'd1, 8'd7, 1'b0, 1'b0);
        tick(1);
        check("post_reset_w", 32'(w), 32'd7);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
